// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: the controller drives the
// start/stop/enable/mode/load side, the timer returns count and status.
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             en;
  logic             periodic;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output start, stop, en, periodic, load_val,
    input  count, running, expired, done
  );

  modport slave (
    input  start, stop, en, periodic, load_val,
    output count, running, expired, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse, usable one-shot or
// periodic. Expiry happens on the enabled edge that finds count already 0,
// so a load of N gives a pulse N+1 enabled cycles after start.
//
// state | meaning
// IDLE  | stopped, count frozen at its last value
// RUN   | counting down on enabled edges
// DONE  | one-shot expired, count parked at 0
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  countdown_timer_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expired_d;
  logic             expired_q;
  logic             running_q;
  logic             done_q;

  // Next-state decode; stop outranks start, start outranks counting.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          count_d  = bus.load_val;
          reload_d = bus.load_val;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
        end else if (bus.start) begin
          count_d  = bus.load_val;
          reload_d = bus.load_val;
        end else if (bus.en) begin
          if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end else begin
            // Terminal count: pulse, then reload or park in DONE at 0.
            expired_d = 1'b1;
            if (bus.periodic) begin
              count_d = reload_q;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and status flags; status decoded from next state so
  // every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the stimulus side runs a behavioural
// model and queues the expected outputs for each edge; a monitor pops and
// compares after every rising edge.
module tb_countdown_timer;
  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expired;
    logic             done;
  } exp_t;

  logic clk;
  logic rst_n;
  countdown_timer_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_no = 0;

  // behavioural model
  bit m_active;
  bit m_done;
  bit m_exp;
  int m_cnt;
  int m_reload;

  function automatic void model_reset();
    m_active = 0; m_done = 0; m_exp = 0; m_cnt = 0; m_reload = 0;
  endfunction

  function automatic void model_edge(bit st, bit sp, bit e, bit per, int ld);
    m_exp = 0;
    if (sp) begin
      m_active = 0;
      m_done   = 0;
    end else if (st) begin
      m_cnt    = ld;
      m_reload = ld;
      m_active = 1;
      m_done   = 0;
    end else if (m_active && e) begin
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
      end else begin
        m_exp = 1;
        if (per) m_cnt = m_reload;
        else begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  endfunction

  task automatic step(bit st, bit sp, bit e, bit per, int ld);
    exp_t x;
    @(negedge clk);
    bus.start    = st;
    bus.stop     = sp;
    bus.en       = e;
    bus.periodic = per;
    bus.load_val = ld[WIDTH-1:0];
    model_edge(st, sp, e, per, ld);
    x.count   = m_cnt[WIDTH-1:0];
    x.running = m_active;
    x.expired = m_exp;
    x.done    = m_done;
    exp_q.push_back(x);
  endtask

  task automatic check_now(string name);
    checks++;
    if (bus.count !== m_cnt[WIDTH-1:0] || bus.running !== m_active ||
        bus.expired !== m_exp || bus.done !== m_done) begin
      errors++;
      $display("FAIL %s: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
               name, bus.count, bus.running, bus.expired, bus.done,
               m_cnt[WIDTH-1:0], m_active, m_exp, m_done);
    end
  endtask

  // monitor: compare each queued expectation just after its edge
  always @(posedge clk) begin
    #1;
    edge_no++;
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      checks++;
      if (bus.count !== x.count || bus.running !== x.running ||
          bus.expired !== x.expired || bus.done !== x.done) begin
        errors++;
        $display("FAIL edge%0d: got cnt=%0d run=%b exp=%b done=%b, want cnt=%0d run=%b exp=%b done=%b",
                 edge_no, bus.count, bus.running, bus.expired, bus.done,
                 x.count, x.running, x.expired, x.done);
      end
    end
  end

  initial begin
    int p, n;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.en       = 1'b0;
    bus.periodic = 1'b0;
    bus.load_val = '0;
    model_reset();
    #2;
    check_now("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    // one-shot load 9
    step(1, 0, 1, 0, 9);
    repeat (13) step(0, 0, 1, 0, 0);

    // periodic load 3
    step(1, 0, 1, 1, 3);
    repeat (14) step(0, 0, 1, 1, 0);

    // load 5 with en toggling
    step(1, 0, 1, 0, 5);
    for (int i = 0; i < 14; i++) step(0, 0, (i % 2) == 0, 0, 0);

    // stop mid-count at 4, restart with 2, then start+stop together
    step(1, 0, 1, 0, 8);
    repeat (4) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 2);
    repeat (4) step(0, 0, 1, 0, 0);
    step(1, 1, 1, 0, 6);
    repeat (2) step(0, 0, 1, 0, 0);

    // async reset between edges at count 7 (load 15)
    step(1, 0, 1, 0, 15);
    repeat (8) step(0, 0, 1, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 1, 1, 9);

    // load 0 one-shot, load 0 periodic, load 15 one-shot
    step(1, 0, 1, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0);
    repeat (4) step(0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 15);
    repeat (18) step(0, 0, 1, 0, 0);

    // restart from DONE
    step(1, 0, 1, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      p = $urandom_range(0, 31);
      n = $urandom_range(0, 15);
      step(p < 2, p == 31, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, n);
    end

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counter with terminal-count detection. It is the counterpart to the team's free-running up-counter: it counts toward zero from a programmed value instead of away from it. It is used as a one-shot or periodic timer by control logic that needs a pulse after N+1 enabled cycles. There is a single clock domain and a small state machine (IDLE/RUN/DONE) around the datapath.

Parameters:
WIDTH, 4, width of load value and count.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  capture load_val and (re)start counting; sampled at clock edge
stop  input  1  abort; return to IDLE, count frozen
en  input  1  count enable; in RUN, count holds when 0
periodic  input  1  1 = auto-reload on expiry, 0 = one-shot; sampled at expiry edge
load_val  input  WIDTH  start value N; captured into internal reload register on start
count  output  WIDTH  current count (registered)
running  output  1  high while state == RUN
expired  output  1  one-cycle pulse on terminal count
done  output  1  high while state == DONE (one-shot finished)

Behaviour:
- Interface (already decided): one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset (async assert, any time including mid-count):
  - state = IDLE; count = 0; reload register = 0.
  - running = 0; expired = 0; done = 0.
  - All outputs are registered, so they change only on a clk edge or on rst_n assertion.
- Priority at each edge: stop > start > counting.
- IDLE:
  - start=1 -> count <= load_val, reload <= load_val, state RUN.
  - Otherwise hold; count keeps its last value.
- RUN:
  - stop=1 -> state IDLE, count holds.
  - start=1 -> restart: count <= load_val, reload <= load_val, stay RUN, no expired pulse.
  - en=0 -> hold everything.
  - en=1 and count != 0 -> count <= count - 1.
  - en=1 and count == 0 -> expiry:
    - expired <= 1 for exactly one cycle.
    - periodic=1: count <= reload, stay RUN.
    - periodic=0: count stays 0, state DONE.
- DONE:
  - done = 1, count = 0.
  - start=1 -> behaves as from IDLE; done clears on the same edge.
  - stop=1 -> IDLE, done clears.
  - No further expired pulses.
- expired is 0 on every edge that is not an expiry edge; it is never high two consecutive cycles unless reload == 0 (see below).
- Timing:
  - With en held 1, expired rises at edge S + N + 1, where S is the start edge.
  - Periodic period = N + 1 cycles.
- Arithmetic: count never wraps below 0; all decrements are modulo-free. load_val = 2^WIDTH - 1 is legal.
- load_val = 0:
  - Enters RUN with count 0; expires on the next enabled edge.
  - Periodic with reload 0 -> expired high every enabled cycle.
- start and stop together -> stop wins, state IDLE.
- en is ignored outside RUN.
- periodic may change while running; only its value at the expiry edge matters.

Test Plan:
- WIDTH=4, load_val=9, periodic=0, en=1, start pulse at edge 0 -> count 9 after edge 0, down to 0 after edge 9; expired=1, done=1 after edge 10 only; running=0 from edge 10; count stays 0.
- load_val=3, periodic=1, en=1 -> count sequence 3,2,1,0,3,2,1,0,...; expired one-cycle pulse every 4 cycles, aligned with each reload to 3; done never set.
- load_val=5, en toggled 1,0,1,0 during RUN -> count decrements only on en=1 edges; expiry at edge S+6 counted in enabled edges only.
- Mid-count (count=4): stop -> running=0, count holds 4, no expired. Restart with load_val=2: start -> count 2, expiry 3 cycles later. start and stop together -> IDLE.
- rst_n pulled low asynchronously between edges at count=7 (load 15) -> count=0, running=0, done=0, expired=0 immediately. After release, no activity until start.
- load_val=0, one-shot -> expired and done after the first enabled edge following start. load_val=15 -> expired at edge S+16, no wrap to 15.
